// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg : shared types and width helpers for fifo_wr_arbiter  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Requester index width; a 1-bit floor keeps NUM_REQ=1 corner legal.
   function automatic int OWNER_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Beat counter must be able to hold MAX_BURST itself.
   function automatic int BCNT_W(input int m);
      return (m > 0) ? $clog2(m + 1) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin picker (rotate, encode, un-rotate)
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int OW      = OWNER_W(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [OW-1:0]      last_i,
   output logic [OW-1:0]      pick_idx_o,
   output logic               pick_vld_o
);

   int                 base;
   int                 enc;
   logic [NUM_REQ-1:0] rot;

   always_comb begin
      base = (int'(last_i) + 1) % NUM_REQ;
      rot  = '0;
      enc  = 0;
      // rot[0] is the highest-priority candidate (last_i + 1)
      for (int i = 0; i < NUM_REQ; i++) begin
         rot[i] = req_i[OW'((i + base) % NUM_REQ)];
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) enc = i;
      end
      pick_vld_o = |req_i;
      pick_idx_o = OW'((enc + base) % NUM_REQ);
   end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter : round-robin burst arbiter for a single FIFO write port
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 8,
   parameter  int MAX_BURST  = 4,
   localparam int OW         = OWNER_W(NUM_REQ),
   localparam int BW         = BCNT_W(MAX_BURST)
) (
   input  logic                          wclk,
   input  logic                          wrst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          full,
   output logic                          w_en,
   output logic [DATA_WIDTH-1:0]         data_in,
   output logic                          busy,
   output logic [OW-1:0]                 owner
);

   arb_state_e            state_q, state_d;
   logic [OW-1:0]         owner_q, owner_d;
   logic [OW-1:0]         last_q,  last_d;
   logic [BW-1:0]         bcnt_q,  bcnt_d;
   logic [OW-1:0]         pick_idx;
   logic                  pick_vld;
   logic                  xfer;
   logic                  last_beat;
   logic [DATA_WIDTH-1:0] slices [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign slices[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i      (req_valid),
      .last_i     (last_q),
      .pick_idx_o (pick_idx),
      .pick_vld_o (pick_vld)
   );

   // full gates the write in the same cycle, so the FIFO never sees write-while-full
   assign xfer      = (state_q == BURST) && req_valid[owner_q] && !full;
   assign last_beat = (bcnt_q == BW'(MAX_BURST - 1));

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q  <= OW'(NUM_REQ - 1);
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         bcnt_q  <= bcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      bcnt_d  = bcnt_q;
      unique case (state_q)
         IDLE: begin
            if (pick_vld) begin
               owner_d = pick_idx;
               bcnt_d  = '0;
               state_d = BURST;
            end
         end
         BURST: begin
            if (xfer) begin
               bcnt_d = bcnt_q + BW'(1);
               if (last_beat) begin
                  state_d = IDLE;
                  last_d  = owner_q;
               end
            end else if (!req_valid[owner_q]) begin
               state_d = IDLE;
               last_d  = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q == BURST);
      w_en      = xfer;
      req_ready = xfer ? (NUM_REQ'(1) << owner_q) : '0;
      data_in   = busy ? slices[owner_q] : '0;
   end

   assign owner = owner_q;

endmodule

`default_nettype wire
